// File: rtl/jk_down_counter_pkg.sv
// ---------------------------------------------------------------------------
// jk_down_counter_pkg
//   Shared types and constants for the loadable JK down counter.
//   - DEFAULT_WIDTH : default counter / load-value width
//   - state_e       : controller state (IDLE, RUN, DONE)
//   - jk_next()     : next-state equation of a JK flip-flop
// ---------------------------------------------------------------------------
package jk_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // J sets, K clears, J=K=1 toggles, J=K=0 holds.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_down_counter_if.sv
// ---------------------------------------------------------------------------
// jk_down_counter_if
//   Control / status bundle of one counter stage.
//   master : drives load, din, en, auto; observes q, tc, done, busy
//   slave  : the counter itself
//   load  - parallel load strobe (starts a count)
//   din   - load value, also captured as the auto-reload value
//   en    - count enable, one decrement per enabled cycle
//   auto  - 1: reload at terminal count, 0: one-shot
//   q     - current count
//   tc    - terminal count (combinational), chains stages
//   done  - one-cycle registered pulse after each terminal event
//   busy  - counter is running
// ---------------------------------------------------------------------------
interface jk_down_counter_if #(
  parameter int WIDTH = jk_down_counter_pkg::DEFAULT_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             auto;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             done;
  logic             busy;

  modport master (
    output load, din, en, auto,
    input  q, tc, done, busy
  );

  modport slave (
    input  load, din, en, auto,
    output q, tc, done, busy
  );
endinterface

// File: rtl/jk_down_counter_jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
//   One synchronous JK flip-flop, synchronous active-high clear.
//   clk  - clock (rising edge)
//   clr  - synchronous clear, wins over J/K
//   j_i  - J input
//   k_i  - K input
//   q_o  - stored bit
// ---------------------------------------------------------------------------
module jk_cell
  import jk_down_counter_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = jk_next(q_q, j_i, k_i);

  always_ff @(posedge clk) begin
    if (clr) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_down_counter.sv
// ---------------------------------------------------------------------------
// jk_down_counter
//   Synchronous, loadable, cascadable down counter built from JK cells.
//   One-shot or auto-reload timer; tc chains stages (lower tc -> upper en).
//   clk  - clock, all state on rising edge
//   clr  - synchronous active-high reset (priority: clr > load > count)
//   bus  - jk_down_counter_if slave: load/din/en/auto in, q/tc/done/busy out
// ---------------------------------------------------------------------------
module jk_down_counter
  import jk_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              clr,
  jk_down_counter_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             q_zero;
  logic             run;
  logic             term;
  logic             cnt_en;

  assign q_zero = (q == '0);
  assign run    = (state_q == RUN);
  // Terminal logic replaces the borrow: at zero we never decrement.
  assign term   = run & bus.en & q_zero;
  assign cnt_en = run & bus.en & ~q_zero;

  // Down-count toggle terms: bit i flips when every lower bit is zero.
  for (genvar i = 0; i < WIDTH; i++) begin : g_tog
    if (i == 0) begin : g_lsb
      assign t[i] = cnt_en;
    end else begin : g_upper
      assign t[i] = cnt_en & (q[i-1:0] == '0);
    end
  end

  // J/K steering: load, reload or toggle; otherwise hold (J=K=0).
  always_comb begin
    j = '0;
    k = '0;
    if (bus.load) begin
      j = bus.din;
      k = ~bus.din;
    end else if (term && bus.auto) begin
      j = reload_q;
      k = ~reload_q;
    end else if (cnt_en) begin
      j = t;
      k = t;
    end
  end

  jk_cell u_cell [WIDTH-1:0] (
    .clk (clk),
    .clr (clr),
    .j_i (j),
    .k_i (k),
    .q_o (q)
  );

  // Controller: state, reload value and the done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else if (bus.load) begin
      reload_q <= bus.din;
      if (bus.din == '0) begin
        // Zero load expires immediately.
        state_q <= DONE;
        done_q  <= 1'b1;
      end else begin
        state_q <= RUN;
        done_q  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.en && q_zero) begin
            done_q <= 1'b1;
            if (!bus.auto) state_q <= DONE;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign bus.q    = q;
  assign bus.tc   = term;
  assign bus.done = done_q;
  assign bus.busy = run;

endmodule

// File: tb/tb_jk_down_counter.sv
module tb_jk_down_counter;
  import jk_down_counter_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  jk_down_counter_if #(.WIDTH(4)) b4 ();
  jk_down_counter_if #(.WIDTH(8)) b8 ();
  jk_down_counter_if #(.WIDTH(4)) bl ();
  jk_down_counter_if #(.WIDTH(4)) bu ();

  jk_down_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .clr(clr), .bus(b4));
  jk_down_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .clr(clr), .bus(b8));
  jk_down_counter #(.WIDTH(4)) u_lo   (.clk(clk), .clr(clr), .bus(bl));
  jk_down_counter #(.WIDTH(4)) u_hi   (.clk(clk), .clr(clr), .bus(bu));

  // Cascade: lower terminal count enables the upper stage.
  assign bu.en = bl.tc;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string      nm;
    logic       clr, load;
    logic [3:0] din;
    logic       en, auto;
    logic       ctc, tc;    // pre-edge tc check
    logic [3:0] q;          // post-edge expectations
    logic       done, busy;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(input string nm, input logic c, input logic ld, input logic [3:0] d,
                              input logic e, input logic a, input logic ctc, input logic tc,
                              input logic [3:0] q, input logic dn, input logic bz);
    vec_t r;
    r.nm = nm; r.clr = c; r.load = ld; r.din = d; r.en = e; r.auto = a;
    r.ctc = ctc; r.tc = tc; r.q = q; r.done = dn; r.busy = bz;
    return r;
  endfunction

  initial begin
    clr = 1'b1;
    b4.load = 0; b4.din = '0; b4.en = 0; b4.auto = 0;
    b8.load = 0; b8.din = '0; b8.en = 0; b8.auto = 0;
    bl.load = 0; bl.din = '0; bl.en = 0; bl.auto = 0;
    bu.load = 0; bu.din = '0; bu.auto = 0;

    //          name        clr ld din en au ctc tc  q  dn bz
    // reset with random other inputs
    v.push_back(mk("rst0",     1, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 0, 0, 0));
    v.push_back(mk("rst1",     1, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1, 0, 0, 0, 0));
    // one-shot from 5
    v.push_back(mk("t2_load",  0, 1, 5, 1, 0, 1, 0, 5, 0, 1));
    v.push_back(mk("t2_c4",    0, 0, 0, 1, 0, 1, 0, 4, 0, 1));
    v.push_back(mk("t2_c3",    0, 0, 0, 1, 0, 1, 0, 3, 0, 1));
    v.push_back(mk("t2_c2",    0, 0, 0, 1, 0, 1, 0, 2, 0, 1));
    v.push_back(mk("t2_c1",    0, 0, 0, 1, 0, 1, 0, 1, 0, 1));
    v.push_back(mk("t2_c0",    0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    v.push_back(mk("t2_term",  0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
    v.push_back(mk("t2_hold1", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    v.push_back(mk("t2_hold2", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // auto-reload from 3
    v.push_back(mk("t3_load",  0, 1, 3, 1, 1, 1, 0, 3, 0, 1));
    v.push_back(mk("t3_c2",    0, 0, 0, 1, 1, 1, 0, 2, 0, 1));
    v.push_back(mk("t3_c1",    0, 0, 0, 1, 1, 1, 0, 1, 0, 1));
    v.push_back(mk("t3_c0",    0, 0, 0, 1, 1, 1, 0, 0, 0, 1));
    v.push_back(mk("t3_rl1",   0, 0, 0, 1, 1, 1, 1, 3, 1, 1));
    v.push_back(mk("t3_c2b",   0, 0, 0, 1, 1, 1, 0, 2, 0, 1));
    v.push_back(mk("t3_c1b",   0, 0, 0, 1, 1, 1, 0, 1, 0, 1));
    v.push_back(mk("t3_c0b",   0, 0, 0, 1, 1, 1, 0, 0, 0, 1));
    v.push_back(mk("t3_rl2",   0, 0, 0, 1, 1, 1, 1, 3, 1, 1));
    // enable pattern and mid-count load
    v.push_back(mk("t4_load",  0, 1, 6, 0, 0, 1, 0, 6, 0, 1));
    v.push_back(mk("t4_e1",    0, 0, 0, 1, 0, 1, 0, 5, 0, 1));
    v.push_back(mk("t4_e0a",   0, 0, 0, 0, 0, 1, 0, 5, 0, 1));
    v.push_back(mk("t4_e0b",   0, 0, 0, 0, 0, 1, 0, 5, 0, 1));
    v.push_back(mk("t4_e1b",   0, 0, 0, 1, 0, 1, 0, 4, 0, 1));
    v.push_back(mk("t4_c3",    0, 0, 0, 1, 0, 1, 0, 3, 0, 1));
    v.push_back(mk("t4_c2",    0, 0, 0, 1, 0, 1, 0, 2, 0, 1));
    v.push_back(mk("t4_ld9",   0, 1, 9, 1, 0, 1, 0, 9, 0, 1));
    v.push_back(mk("t4_hold",  0, 0, 0, 0, 0, 1, 0, 9, 0, 1));
    // clr beats load; zero load expires at once
    v.push_back(mk("t5_load6", 0, 1, 6, 0, 0, 1, 0, 6, 0, 1));
    v.push_back(mk("t5_clr",   1, 1, 3, 1, 0, 1, 0, 0, 0, 0));
    v.push_back(mk("t5_zero",  0, 1, 0, 1, 0, 1, 0, 0, 1, 0));
    v.push_back(mk("t5_aft1",  0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    v.push_back(mk("t5_aft2",  0, 0, 0, 1, 1, 1, 0, 0, 0, 0));

    for (int i = 0; i < v.size(); i++) begin
      clr = v[i].clr; b4.load = v[i].load; b4.din = v[i].din;
      b4.en = v[i].en; b4.auto = v[i].auto;
      #1;
      if (v[i].ctc) chk({v[i].nm, " tc"}, 32'(b4.tc), 32'(v[i].tc));
      @(posedge clk); #1;
      chk({v[i].nm, " q"},    32'(b4.q),    32'(v[i].q));
      chk({v[i].nm, " done"}, 32'(b4.done), 32'(v[i].done));
      chk({v[i].nm, " busy"}, 32'(b4.busy), 32'(v[i].busy));
    end
    clr = 1'b0; b4.load = 0; b4.en = 0;

    // 8-bit one-shot from 255
    b8.load = 1; b8.din = 8'd255; b8.en = 1; b8.auto = 0;
    @(posedge clk); #1;
    b8.load = 0;
    chk("w8 load q", 32'(b8.q), 32'd255);
    for (int kk = 1; kk <= 257; kk++) begin
      @(posedge clk); #1;
      if (kk <= 255) chk($sformatf("w8 q@%0d", kk), 32'(b8.q), 32'(255 - kk));
      chk($sformatf("w8 tc@%0d", kk),   32'(b8.tc),   32'(kk == 255));
      chk($sformatf("w8 done@%0d", kk), 32'(b8.done), 32'(kk == 256));
    end
    chk("w8 end q", 32'(b8.q), 32'd0);
    chk("w8 end busy", 32'(b8.busy), 32'd0);
    b8.en = 0;

    // Two cascaded 4-bit stages: 16x16 counts
    bl.load = 1; bl.din = 4'd15; bl.en = 1; bl.auto = 1;
    bu.load = 1; bu.din = 4'd15; bu.auto = 0;
    @(posedge clk); #1;
    bl.load = 0; bu.load = 0;
    chk("cas load", 32'({bu.q, bl.q}), 32'd255);
    for (int kk = 1; kk <= 257; kk++) begin
      @(posedge clk); #1;
      if (kk <= 255) chk($sformatf("cas q@%0d", kk), 32'({bu.q, bl.q}), 32'(255 - kk));
      chk($sformatf("cas done@%0d", kk), 32'(bu.done), 32'(kk == 256));
      chk($sformatf("cas busy@%0d", kk), 32'(bu.busy), 32'(kk < 256));
    end
    bl.en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
